matrix_scan_driver: RTL and testbench
=====================================

Name: matrix_scan_driver

Overview:
- Parametrised row-multiplexed LED matrix driver; successor to the single-pixel 16x16 scanner.
- Scans one full row per slot instead of one pixel per clock, so the duty cycle per LED is 1/ROWS rather than 1/(ROWS*COLS).
- Adds double-buffered frame loading with a valid/ready handshake, inter-row blanking (anti-ghosting) and 16-level global brightness.
- Sits between the game-of-life core (frame producer) and the matrix row/column pins.

Parameters:
- ROWS, 16, number of matrix rows; must be >= 2.
- COLS, 16, number of matrix columns; must be >= 1.
- DWELL_LOG2, 10, log2 of drive cycles per row; must be >= 4.
- BLANK_CYC, 16, all-off cycles before each row's drive slot; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_data  in  ROWS*COLS  frame; bit r*COLS+c = pixel (row r, col c), 1 = lit.
- load_valid  in  1  producer offers load_data.
- load_ready  out  1  pending buffer empty; transfer occurs when load_valid && load_ready at a clk edge.
- brightness  in  4  global brightness, 0 = dimmest (1/16 on), 15 = full.
- R  out  ROWS  row drives, active-low (1 = row off).
- C  out  COLS  column drives, active-high (1 = LED on).
- row_idx  out  clog2(ROWS)  row currently in BLANK/DRIVE.
- frame_done  out  1  one-cycle pulse at end of the last row's drive slot.

Behaviour:
- Reset (asynchronous, immediate even mid-scan):
  - Outputs: R = all 1, C = all 0, frame_done = 0, row_idx = 0, load_ready = 1.
  - Internal: display buffer = 0, pending buffer empty, state = BLANK, counters = 0.
- States: BLANK and DRIVE only.
  - BLANK: counter counts 0..BLANK_CYC-1, then goes to DRIVE with the counter cleared.
  - DRIVE: counter counts 0..2^DWELL_LOG2-1, then goes to BLANK with row_idx+1.
  - After row ROWS-1, row_idx wraps to 0.
- Frame period = ROWS*(BLANK_CYC + 2^DWELL_LOG2) cycles; it is independent of frame content.
- Outputs are registered and reflect the state/counter of the previous cycle (1-cycle latency).
- Output values:
  - BLANK: R = all 1, C = all 0.
  - DRIVE, on-window: R[row_idx] = 0, other rows = 1; C = display row row_idx (bits row_idx*COLS +: COLS).
  - On-window condition: cnt < ((brightness+1) << (DWELL_LOG2-4)).
  - DRIVE, outside on-window: C = 0, R as above.
  - brightness is sampled every cycle; a change takes effect mid-row.
- Handshake:
  - load_ready = ~pending_full.
  - On accept: pending <= load_data, pending_full <= 1.
  - load_data is ignored when load_ready = 0.
- Swap:
  - Occurs at the edge ending DRIVE of row ROWS-1, the same edge on which frame_done is asserted.
  - If pending_full: display <= pending, pending_full <= 0, and load_ready = 1 on the next cycle.
  - If pending is empty, the display keeps the old frame.
  - The displayed frame never changes mid-frame (no tearing).
- Simultaneous events:
  - An accept on the swap edge with pending empty is stored in pending.
  - That frame is displayed only after the following frame end.
- Widths: internal counter is max(DWELL_LOG2, clog2(BLANK_CYC)) + 1 bits. The brightness shift is computed at DWELL_LOG2+1 bits, so no overflow at brightness = 15.

Test Plan:
Use ROWS=4, COLS=4, DWELL_LOG2=4, BLANK_CYC=2 for all scenarios.
1. Reset: assert rst_n=0 mid-DRIVE -> R=4'b1111, C=0 in the same cycle, load_ready=1. After release, row 0 BLANK lasts 2 cycles, then R=4'b1110.
2. Load 16'h8421 while idle, brightness=15 -> after the first frame_done:
   - row r drives C = 1<<r for 16 cycles each, with R=1110/1101/1011/0111.
   - frame_done period = 72 cycles.
3. brightness=0 -> C nonzero for exactly 1 cycle of each 16-cycle dwell. brightness=7 -> C nonzero for exactly 8 cycles.
4. Back-pressure:
   - Load frame A, then hold load_valid with frame B -> load_ready=0 until the frame end.
   - A is shown; B is accepted the cycle after the swap and is shown one frame later.
   - No tearing: the row contents stay constant within every frame.
5. Load offered exactly on the frame_done edge with pending empty -> accepted; the display changes only at the next frame_done.
6. No load after reset -> C stays 0 in every DRIVE for 3 full frames; row_idx cycles 0,1,2,3,0.

Source files
------------

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed LED matrix driver: one full row per slot, blanking gap before
// each row, double-buffered frame load and 16-level global brightness.
module matrix_scan_driver #(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DWELL_LOG2 = 10,
    parameter int BLANK_CYC  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROWS*COLS-1:0]     load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [3:0]               brightness,
    output logic [ROWS-1:0]          R,
    output logic [COLS-1:0]          C,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     frame_done
);
    localparam int RW  = $clog2(ROWS);
    localparam int BW  = $clog2(BLANK_CYC);
    localparam int CW  = ((DWELL_LOG2 > BW) ? DWELL_LOG2 : BW) + 1;
    localparam int LW  = DWELL_LOG2 + 1;

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [RW-1:0]         r_row, w_row_nxt;
    logic [ROWS*COLS-1:0]  r_disp, r_pend;
    logic                  r_pfull;
    logic [ROWS-1:0]       r_R, w_R_nxt;
    logic [COLS-1:0]       r_C, w_C_nxt;
    logic [RW-1:0]         r_row_idx;
    logic                  r_frame_done;

    logic                  w_blank_end, w_drive_end, w_frame_end;
    logic                  w_accept, w_swap;
    logic [LW-1:0]         w_on_lim;

    assign w_blank_end = (r_state == ST_BLANK) && (r_cnt == CW'(BLANK_CYC - 1));
    assign w_drive_end = (r_state == ST_DRIVE) && (r_cnt == CW'((1 << DWELL_LOG2) - 1));
    assign w_frame_end = w_drive_end && (r_row == RW'(ROWS - 1));

    // The swap and an accept are exclusive: an accept needs an empty pending buffer.
    assign w_accept = load_valid && !r_pfull;
    assign w_swap   = w_frame_end && r_pfull;

    // Computed one bit wider than the dwell so brightness 15 gives exactly 2^DWELL_LOG2.
    assign w_on_lim = ({{(LW-4){1'b0}}, brightness} + LW'(1)) << (DWELL_LOG2 - 4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_row_nxt   = r_row;
        if (w_blank_end) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
        end else if (w_drive_end) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_row_nxt   = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        end
    end

    always_comb begin
        w_R_nxt = '1;
        w_C_nxt = '0;
        if (r_state == ST_DRIVE) begin
            w_R_nxt[r_row] = 1'b0;
            if (r_cnt < CW'(w_on_lim))
                w_C_nxt = r_disp[r_row*COLS +: COLS];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp       <= '0;
            r_pend       <= '0;
            r_pfull      <= 1'b0;
            r_R          <= '1;
            r_C          <= '0;
            r_row_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_R          <= w_R_nxt;
            r_C          <= w_C_nxt;
            r_row_idx    <= r_row;
            r_frame_done <= w_frame_end;
            if (w_swap) begin
                r_disp  <= r_pend;
                r_pfull <= 1'b0;
            end
            if (w_accept) begin
                r_pend  <= load_data;
                r_pfull <= 1'b1;
            end
        end
    end

    assign load_ready = ~r_pfull;
    assign R          = r_R;
    assign C          = r_C;
    assign row_idx    = r_row_idx;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver: a time-indexed frame model predicts
// every output cycle; a separate monitor pops and compares.
module tb_matrix_scan_driver;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DL    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = BC + (1 << DL);
    localparam int FRAME = ROWS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_valid = 1'b0;
    logic [3:0]  brightness = '0;
    logic        load_ready;
    logic [3:0]  R, C;
    logic [1:0]  row_idx;
    logic        frame_done;

    matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .DWELL_LOG2(DL), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .brightness(brightness), .R(R), .C(C),
        .row_idx(row_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] R;
        logic [3:0] C;
        logic [1:0] row;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          t = 0;
    logic        m_pfull = 1'b0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_disp = '0;

    // Reference: position in the frame follows purely from edges since reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0; m_pfull = 1'b0; m_pend = '0; m_disp = '0;
                q.delete();
            end else begin
                int   p, row, o, b;
                logic acc, sw;
                exp_t e;
                p = t % FRAME; row = p / SLOT; o = p % SLOT; b = int'(brightness);
                e.R = 4'hF; e.C = 4'h0;
                if (o >= BC) begin
                    e.R = ~(4'b0001 << row);
                    if ((o - BC) < b + 1) e.C = m_disp[row*COLS +: COLS];
                end
                e.row = 2'(row);
                e.fd  = (p == FRAME - 1);
                acc = load_valid && !m_pfull;
                sw  = (p == FRAME - 1) && m_pfull;
                if (sw) begin m_disp = m_pend; m_pfull = 1'b0; end
                if (acc) begin m_pend = load_data; m_pfull = 1'b1; end
                e.rdy = !m_pfull;
                q.push_back(e);
                t++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (R !== e.R || C !== e.C || row_idx !== e.row || frame_done !== e.fd || load_ready !== e.rdy) begin
                    failures++;
                    $display("FAIL scan t=%0d got R=%b C=%b row=%0d fd=%b rdy=%b exp R=%b C=%b row=%0d fd=%b rdy=%b",
                             t, R, C, row_idx, frame_done, load_ready, e.R, e.C, e.row, e.fd, e.rdy);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        brightness = 4'd15;
        cyc(3 * FRAME + 5);

        load_data = 16'h8421; load_valid = 1'b1; cyc(1); load_valid = 1'b0;
        cyc(2 * FRAME);
        brightness = 4'd0; cyc(FRAME);
        brightness = 4'd7; cyc(FRAME);

        brightness = 4'd15;
        load_data = 16'hA5C3; load_valid = 1'b1; cyc(1);
        load_data = 16'h3C5A; cyc(100);
        load_valid = 1'b0; cyc(150);

        for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) cyc(1);
        load_data = 16'h1248; load_valid = 1'b1; cyc(1); load_valid = 1'b0;
        cyc(2 * FRAME);

        for (int i = 0; i < 800; i++) begin
            load_valid = ($urandom_range(0, 5) == 0);
            load_data  = 16'($urandom);
            brightness = 4'($urandom);
            cyc(1);
        end
        load_valid = 1'b0;
        brightness = 4'd15;

        for (int i = 0; i < SLOT && (t % SLOT) != 10; i++) cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_R", {4'h0, R}, 8'h0F);
        chk("rst_C", {4'h0, C}, 8'h00);
        chk("rst_ready", {7'h0, load_ready}, 8'h01);
        chk("rst_fd", {7'h0, frame_done}, 8'h00);
        chk("rst_row", {6'h0, row_idx}, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(FRAME + 10);

        checks++;
        if (checks < 1500) begin
            failures++;
            $display("FAIL scan_count got=%0d exp>=1500", checks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
